// File: rtl/local_mem_banked.sv
// Banked scratchpad: NUM_REQS lanes share NUM_BANKS word-interleaved single-port banks
// through per-bank round-robin arbitration, with one registered response slot per lane.
module local_mem_banked #(
  parameter int          NUM_REQS   = 4,
  parameter int          NUM_BANKS  = 4,
  parameter int          DATA_WIDTH = 32,
  parameter int          SIZE_BYTE  = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          TAG_WIDTH  = 8,
  parameter bit          BROADCAST  = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQS-1:0]                 req_valid_i,
  output logic [NUM_REQS-1:0]                 req_ready_o,
  input  logic [NUM_REQS-1:0]                 req_we_i,
  input  logic [NUM_REQS*32-1:0]              req_addr_i,
  input  logic [NUM_REQS*(DATA_WIDTH/8)-1:0]  req_be_i,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]       req_tag_i,
  output logic [NUM_REQS-1:0]                 rsp_valid_o,
  input  logic [NUM_REQS-1:0]                 rsp_ready_i,
  output logic [NUM_REQS*DATA_WIDTH-1:0]      rsp_rdata_o,
  output logic [NUM_REQS*TAG_WIDTH-1:0]       rsp_tag_o,
  output logic [NUM_REQS-1:0]                 rsp_err_o
);
  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(WORD_BYTES);
  localparam int BANK_BITS  = $clog2(NUM_BANKS);
  localparam int BW         = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROWS       = SIZE_BYTE / (NUM_BANKS * WORD_BYTES);
  localparam int ROW_BITS   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_REQS-1:0]                 in_win, elig, grant;
  logic [NUM_REQS-1:0][BW-1:0]         lane_bank;
  logic [NUM_REQS-1:0][ROW_BITS-1:0]   lane_row;
  logic [LW-1:0]                       rr_reg  [NUM_BANKS];
  logic [LW-1:0]                       rr_next [NUM_BANKS];
  logic [NUM_BANKS-1:0]                bank_act, bank_we;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0]  bank_row;
  logic [NUM_BANKS-1:0][WORD_BYTES-1:0] bank_be;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata;
  logic [DATA_WIDTH-1:0]               bank_rdata [NUM_BANKS];

  logic [NUM_REQS-1:0]                 rsp_valid_reg, rsp_err_reg, rsp_fresh_reg;
  logic [NUM_REQS-1:0][BW-1:0]         rsp_bank_reg;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] rsp_hold_reg;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  rsp_tag_reg;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lane
    logic [31:0] addr, offset, word;
    assign addr   = req_addr_i[gi*32 +: 32];
    assign offset = addr - BASE_ADDR;
    assign word   = offset >> OFF_BITS;
    assign in_win[gi]    = (addr >= BASE_ADDR) && (offset < SIZE_BYTE);
    assign lane_bank[gi] = BW'(word % NUM_BANKS);
    assign lane_row[gi]  = ROW_BITS'(word >> BANK_BITS);
    assign elig[gi] = rst_ni && req_valid_i[gi] && (!rsp_valid_reg[gi] || rsp_ready_i[gi]);
    // Bank read data is live only the cycle after the grant; afterwards the slot's copy is used.
    assign rsp_rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] =
      rsp_fresh_reg[gi] ? bank_rdata[rsp_bank_reg[gi]] : rsp_hold_reg[gi];
    assign rsp_tag_o[gi*TAG_WIDTH +: TAG_WIDTH] = rsp_tag_reg[gi];
  end

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign req_ready_o = grant;

  always_comb begin
    logic found;
    int   win;
    int   lane;
    found      = 1'b0;
    win        = 0;
    lane       = 0;
    grant      = '0;
    bank_act   = '0;
    bank_we    = '0;
    bank_row   = '0;
    bank_be    = '0;
    bank_wdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) rr_next[b] = rr_reg[b];
    for (int i = 0; i < NUM_REQS; i++) begin
      if (elig[i] && !in_win[i]) grant[i] = 1'b1;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
        lane = (int'(rr_reg[b]) + k) % NUM_REQS;
        if (!found && elig[lane] && in_win[lane] && lane_bank[lane] == BW'(b)) begin
          found = 1'b1;
          win   = lane;
        end
      end
      if (found) begin
        grant[win]    = 1'b1;
        bank_act[b]   = 1'b1;
        bank_we[b]    = req_we_i[win];
        bank_row[b]   = lane_row[win];
        bank_be[b]    = req_be_i[win*WORD_BYTES +: WORD_BYTES];
        bank_wdata[b] = req_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
        rr_next[b]    = LW'((win + 1) % NUM_REQS);
        if (BROADCAST && !req_we_i[win]) begin
          for (int i = 0; i < NUM_REQS; i++) begin
            if (elig[i] && in_win[i] && !req_we_i[i] && lane_bank[i] == BW'(b) &&
                lane_row[i] == lane_row[win])
              grant[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_reg[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) rr_reg[b] <= rr_next[b];
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [DATA_WIDTH-1:0] rdata_reg;
    always_ff @(posedge clk_i) begin
      if (bank_act[gi]) begin
        if (bank_we[gi]) begin
          for (int j = 0; j < WORD_BYTES; j++) begin
            if (bank_be[gi][j]) mem[bank_row[gi]][j*8 +: 8] <= bank_wdata[gi][j*8 +: 8];
          end
        end else begin
          rdata_reg <= mem[bank_row[gi]];
        end
      end
    end
    assign bank_rdata[gi] = rdata_reg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_reg <= '0;
      rsp_err_reg   <= '0;
      rsp_fresh_reg <= '0;
      rsp_bank_reg  <= '0;
      rsp_hold_reg  <= '0;
      rsp_tag_reg   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (grant[i]) begin
          rsp_valid_reg[i] <= 1'b1;
          rsp_err_reg[i]   <= !in_win[i];
          rsp_fresh_reg[i] <= in_win[i] && !req_we_i[i];
          rsp_bank_reg[i]  <= lane_bank[i];
          rsp_hold_reg[i]  <= '0;
          rsp_tag_reg[i]   <= req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
        end else begin
          if (rsp_valid_reg[i] && rsp_ready_i[i]) rsp_valid_reg[i] <= 1'b0;
          if (rsp_fresh_reg[i]) begin
            rsp_hold_reg[i]  <= bank_rdata[rsp_bank_reg[i]];
            rsp_fresh_reg[i] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_local_mem_banked.sv
// Directed bench for local_mem_banked: two instances (no broadcast / broadcast) share stimulus,
// each checked every cycle against a word-level memory model, plus hand-computed expectations.
module tb_local_mem_banked;
  localparam int NR = 4, NB = 4, DW = 32, SZ = 1024, TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    valid, we, rsp_rdy;
  logic [NR*32-1:0] addr;
  logic [NR*4-1:0]  be;
  logic [NR*DW-1:0] wdata;
  logic [NR*TW-1:0] tag;
  logic [NR-1:0]    rdy    [2];
  logic [NR-1:0]    rvalid [2];
  logic [NR*DW-1:0] rdata  [2];
  logic [NR*TW-1:0] rtag   [2];
  logic [NR-1:0]    rerr   [2];

  local_mem_banked #(.NUM_REQS(NR), .NUM_BANKS(NB), .DATA_WIDTH(DW), .SIZE_BYTE(SZ),
    .BASE_ADDR(32'h0), .TAG_WIDTH(TW), .BROADCAST(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(rdy[0]), .req_we_i(we),
    .req_addr_i(addr), .req_be_i(be), .req_wdata_i(wdata), .req_tag_i(tag),
    .rsp_valid_o(rvalid[0]), .rsp_ready_i(rsp_rdy), .rsp_rdata_o(rdata[0]),
    .rsp_tag_o(rtag[0]), .rsp_err_o(rerr[0]));

  local_mem_banked #(.NUM_REQS(NR), .NUM_BANKS(NB), .DATA_WIDTH(DW), .SIZE_BYTE(SZ),
    .BASE_ADDR(32'h0), .TAG_WIDTH(TW), .BROADCAST(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(rdy[1]), .req_we_i(we),
    .req_addr_i(addr), .req_be_i(be), .req_wdata_i(wdata), .req_tag_i(tag),
    .rsp_valid_o(rvalid[1]), .rsp_ready_i(rsp_rdy), .rsp_rdata_o(rdata[1]),
    .rsp_tag_o(rtag[1]), .rsp_err_o(rerr[1]));

  int checks = 0;
  int errors = 0;

  // Reference state per instance: byte memory with known flags, response slots, rr pointers.
  logic [7:0]  mem_b   [2][SZ];
  bit          known_b [2][SZ];
  bit          m_v     [2][NR];
  logic [31:0] m_data  [2][NR];
  bit          m_dk    [2][NR];
  logic [7:0]  m_tag   [2][NR];
  bit          m_err   [2][NR];
  int          m_rr    [2][NB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_addr(input int i);
    return addr[i*32 +: 32];
  endfunction

  task automatic model_cycle(input int d);
    logic [NR-1:0] g, el;
    logic [31:0]   a, wa;
    bit            found;
    int            win, l;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_v[d][i] = 1'b0;
      for (int b = 0; b < NB; b++) m_rr[d][b] = 0;
      chk($sformatf("rst_ready d%0d", d), 32'(rdy[d]), 32'h0);
      chk($sformatf("rst_valid d%0d", d), 32'(rvalid[d]), 32'h0);
      chk($sformatf("rst_err d%0d", d), 32'(rerr[d]), 32'h0);
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("rst_rdata d%0d l%0d", d, i), rdata[d][i*32 +: 32], 32'h0);
        chk($sformatf("rst_tag d%0d l%0d", d, i), 32'(rtag[d][i*8 +: 8]), 32'h0);
      end
      return;
    end
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rsp_valid d%0d l%0d", d, i), 32'(rvalid[d][i]), 32'(m_v[d][i]));
      if (m_v[d][i]) begin
        chk($sformatf("rsp_tag d%0d l%0d", d, i), 32'(rtag[d][i*8 +: 8]), 32'(m_tag[d][i]));
        chk($sformatf("rsp_err d%0d l%0d", d, i), 32'(rerr[d][i]), 32'(m_err[d][i]));
        if (m_dk[d][i])
          chk($sformatf("rsp_rdata d%0d l%0d", d, i), rdata[d][i*32 +: 32], m_data[d][i]);
      end
    end
    g = '0;
    for (int i = 0; i < NR; i++) begin
      el[i] = valid[i] && (!m_v[d][i] || rsp_rdy[i]);
      if (el[i] && lane_addr(i) >= SZ) g[i] = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      found = 1'b0;
      win = 0;
      for (int k = 0; k < NR; k++) begin
        l = (m_rr[d][b] + k) % NR;
        a = lane_addr(l);
        if (!found && el[l] && a < SZ && ((a >> 2) % NB) == b) begin
          found = 1'b1;
          win = l;
        end
      end
      if (found) begin
        g[win] = 1'b1;
        m_rr[d][b] = (win + 1) % NR;
        if (d == 1 && !we[win])
          for (int i = 0; i < NR; i++)
            if (el[i] && !we[i] && lane_addr(i) < SZ && (lane_addr(i) >> 2) == (lane_addr(win) >> 2))
              g[i] = 1'b1;
      end
    end
    chk($sformatf("req_ready d%0d", d), 32'(rdy[d]), 32'(g));
    for (int i = 0; i < NR; i++)
      if (m_v[d][i] && rsp_rdy[i]) m_v[d][i] = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (g[i]) begin
        a = lane_addr(i);
        wa = {a[31:2], 2'b00};
        m_v[d][i] = 1'b1;
        m_tag[d][i] = tag[i*8 +: 8];
        m_err[d][i] = (a >= SZ);
        m_data[d][i] = 32'h0;
        m_dk[d][i] = 1'b1;
        if (a < SZ && !we[i])
          for (int j = 0; j < 4; j++) begin
            m_data[d][i][j*8 +: 8] = mem_b[d][wa + j];
            if (!known_b[d][wa + j]) m_dk[d][i] = 1'b0;
          end
      end
    end
    for (int i = 0; i < NR; i++) begin
      a = lane_addr(i);
      wa = {a[31:2], 2'b00};
      if (g[i] && we[i] && a < SZ)
        for (int j = 0; j < 4; j++)
          if (be[i*4 + j]) begin
            mem_b[d][wa + j] = wdata[i*32 + j*8 +: 8];
            known_b[d][wa + j] = 1'b1;
          end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input logic [7:0] t);
    valid[i] = 1'b1;
    we[i] = w;
    addr[i*32 +: 32] = a;
    be[i*4 +: 4] = b;
    wdata[i*32 +: 32] = wd;
    tag[i*8 +: 8] = t;
  endtask

  logic [3:0] exp_gnt [6];

  initial begin
    valid = '0; we = '0; addr = '0; be = '0; wdata = '0; tag = '0; rsp_rdy = '1;
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    step(); step();
    chk("reset_valid", 32'(rvalid[0]), 32'h0);
    chk("reset_ready", 32'(rdy[0]), 32'h0);
    rst_n = 1'b1;
    step();

    // Conflict-free writes then reads
    for (int i = 0; i < NR; i++) lane(i, 1'b1, 32'(4*i), 4'hF, 32'hA0 + 32'(i), 8'h10 + 8'(i));
    #1;
    chk("cf_wr_ready d0", 32'(rdy[0]), 32'hF);
    chk("cf_wr_ready d1", 32'(rdy[1]), 32'hF);
    step();
    for (int i = 0; i < NR; i++) lane(i, 1'b0, 32'(4*i), 4'h0, 32'h0, 8'h20 + 8'(i));
    #1;
    chk("cf_rd_ready d0", 32'(rdy[0]), 32'hF);
    step();
    valid = '0;
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("cf_rdata l%0d", i), rdata[0][i*32 +: 32], 32'hA0 + 32'(i));
      chk($sformatf("cf_tag l%0d", i), 32'(rtag[0][i*8 +: 8]), 32'h20 + 32'(i));
    end

    // Preload words used by the conflict and broadcast cases
    lane(0, 1'b1, 32'h10, 4'hF, 32'h11111111, 8'h30); step();
    lane(0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 8'h31); step();
    valid = '0; step();
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1;

    // Same-bank reads from reset
    for (int i = 0; i < NR; i++) lane(i, 1'b0, 32'h10, 4'h0, 32'h0, 8'h40 + 8'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("conflict_grant c%0d", k), 32'(rdy[0]), 32'(exp_gnt[k]));
      chk($sformatf("conflict_bcast c%0d", k), 32'(rdy[1]), 32'hF);
      step();
    end
    chk("conflict_last_valid", 32'(rvalid[0]), 32'h2);
    chk("conflict_last_rdata", rdata[0][1*32 +: 32], 32'h11111111);

    // Broadcast read of one word by all lanes
    for (int i = 0; i < NR; i++) lane(i, 1'b0, 32'h20, 4'h0, 32'h0, 8'h50 + 8'(i));
    #1;
    chk("bcast_ready d1", 32'(rdy[1]), 32'hF);
    chk("bcast_ready d0", 32'(rdy[0]), 32'h4);
    step();
    valid = '0;
    chk("bcast_valid", 32'(rvalid[1]), 32'hF);
    for (int i = 0; i < NR; i++)
      chk($sformatf("bcast_rdata l%0d", i), rdata[1][i*32 +: 32], 32'hCAFEF00D);
    step(); step();

    // Byte enables, then read the cycle after the second write's ack
    lane(2, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, 8'h60); step();
    lane(2, 1'b1, 32'h40, 4'b0101, 32'h12345678, 8'h61); step();
    lane(2, 1'b0, 32'h40, 4'h0, 32'h0, 8'h62); step();
    valid = '0;
    chk("be_rdata d0", rdata[0][2*32 +: 32], 32'hFF34FF78);
    chk("be_rdata d1", rdata[1][2*32 +: 32], 32'hFF34FF78);
    chk("be_tag", 32'(rtag[0][2*8 +: 8]), 32'h62);
    step();

    // Back-pressure on lane 1, then an out-of-window read
    rsp_rdy[1] = 1'b0;
    lane(1, 1'b0, 32'h04, 4'h0, 32'h0, 8'h70);
    #1;
    chk("bp_first_grant", 32'(rdy[0][1]), 32'h1);
    step();
    lane(1, 1'b0, 32'h400, 4'h0, 32'h0, 8'h71);
    #1;
    chk("bp_blocked0", 32'(rdy[0][1]), 32'h0);
    step();
    chk("bp_held_valid", 32'(rvalid[0][1]), 32'h1);
    chk("bp_held_rdata", rdata[0][1*32 +: 32], 32'hA1);
    chk("bp_blocked1", 32'(rdy[0][1]), 32'h0);
    rsp_rdy[1] = 1'b1;
    #1;
    chk("bp_refill", 32'(rdy[0][1]), 32'h1);
    step();
    valid = '0;
    chk("err_flag", 32'(rerr[0][1]), 32'h1);
    chk("err_rdata", rdata[0][1*32 +: 32], 32'h0);
    chk("err_tag", 32'(rtag[0][1*8 +: 8]), 32'h71);
    step();

    // Async reset with four pending responses
    rsp_rdy = '0;
    for (int i = 0; i < NR; i++) lane(i, 1'b0, 32'(4*i), 4'h0, 32'h0, 8'h80 + 8'(i));
    step();
    valid = '0;
    chk("pend_valid d0", 32'(rvalid[0]), 32'hF);
    chk("pend_valid d1", 32'(rvalid[1]), 32'hF);
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst d0", 32'(rvalid[0]), 32'h0);
    chk("async_rst d1", 32'(rvalid[1]), 32'h0);
    step();
    rst_n = 1'b1;
    rsp_rdy = '1;
    for (int i = 0; i < NR; i++) lane(i, 1'b0, 32'h30, 4'h0, 32'h0, 8'h90 + 8'(i));
    #1;
    chk("post_rst_grant", 32'(rdy[0]), 32'h1);
    step();
    valid = '0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
